// File: rtl/mips_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : mips_instr_encoder
// Purpose  : Encodes MIPS operation requests into 32-bit instruction words
//            with the matching expected ALU control value, buffered in a
//            small FIFO drained over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module mips_instr_encoder #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [4:0]  req_rs,
    input  logic [4:0]  req_rt,
    input  logic [4:0]  req_rd,
    input  logic [15:0] req_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [2:0]  out_alu_ctrl,
    output logic        err,
    output logic [7:0]  err_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [5:0] c_funct_add = 6'b100000;
    localparam logic [5:0] c_funct_sub = 6'b100010;
    localparam logic [5:0] c_funct_and = 6'b100100;
    localparam logic [5:0] c_funct_or  = 6'b100101;
    localparam logic [5:0] c_funct_slt = 6'b101010;
    localparam logic [5:0] c_op_addi   = 6'b001000;
    localparam logic [5:0] c_op_ori    = 6'b001101;
    localparam logic [5:0] c_op_slti   = 6'b001010;
    localparam logic [5:0] c_op_andi   = 6'b001100;
    localparam logic [5:0] c_op_beq    = 6'b000100;
    localparam logic [5:0] c_op_bne    = 6'b000101;

    logic [31:0]   r_mem_instr [DEPTH];
    logic [2:0]    r_mem_ctrl  [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_err;
    logic [7:0]    r_err_count;

    logic          w_legal;
    logic [31:0]   w_instr;
    logic [2:0]    w_ctrl;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;

    // Encode the incoming request into an instruction word and ALU control
    always_comb begin
        w_legal = 1'b1;
        w_instr = '0;
        w_ctrl  = '0;
        case (req_op)
            4'd0:  begin w_instr = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, c_funct_add}; w_ctrl = 3'b010; end
            4'd1:  begin w_instr = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, c_funct_sub}; w_ctrl = 3'b110; end
            4'd2:  begin w_instr = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, c_funct_and}; w_ctrl = 3'b000; end
            4'd3:  begin w_instr = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, c_funct_or};  w_ctrl = 3'b001; end
            4'd4:  begin w_instr = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, c_funct_slt}; w_ctrl = 3'b111; end
            4'd5:  begin w_instr = {c_op_addi, req_rs, req_rt, req_imm}; w_ctrl = 3'b010; end
            4'd6:  begin w_instr = {c_op_ori,  req_rs, req_rt, req_imm}; w_ctrl = 3'b001; end
            4'd7:  begin w_instr = {c_op_slti, req_rs, req_rt, req_imm}; w_ctrl = 3'b111; end
            4'd8:  begin w_instr = {c_op_andi, req_rs, req_rt, req_imm}; w_ctrl = 3'b000; end
            4'd9:  begin w_instr = {c_op_beq,  req_rs, req_rt, req_imm}; w_ctrl = 3'b101; end
            4'd10: begin w_instr = {c_op_bne,  req_rs, req_rt, req_imm}; w_ctrl = 3'b011; end
            default: w_legal = 1'b0;
        endcase
    end

    // Handshake status comes from the registered count only
    assign req_ready    = (r_count != CW'(DEPTH));
    assign out_valid    = (r_count != '0);
    assign w_accept     = req_valid && req_ready;
    assign w_push       = w_accept && w_legal;
    assign w_pop        = out_valid && out_ready;
    assign out_instr    = out_valid ? r_mem_instr[r_rptr] : 32'd0;
    assign out_alu_ctrl = out_valid ? r_mem_ctrl[r_rptr]  : 3'd0;
    assign err          = r_err;
    assign err_count    = r_err_count;

    // Storage array needs no reset; only valid slots are ever presented
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_instr[r_wptr] <= w_instr;
            r_mem_ctrl[r_wptr]  <= w_ctrl;
        end
    end

    // FIFO pointers/count and illegal-request tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
            r_err <= w_accept && !w_legal;
            if (w_accept && !w_legal && (r_err_count != 8'hFF))
                r_err_count <= r_err_count + 8'd1;
        end
    end

endmodule
`default_nettype wire
